// File: rtl/enc_pkg.sv
// Shared constants and helpers for the event encoder and related arbiters.
package enc_pkg;
    localparam int N = 8;
    localparam int W = 3;

    localparam logic PRIO_FIXED = 1'b0;
    localparam logic PRIO_RR    = 1'b1;

    function automatic logic [W-1:0] onehot_to_bin(input logic [N-1:0] oh);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) b = b | W'(i);
        end
        return b;
    endfunction
endpackage

// File: rtl/event_encoder8_3_prio_pick.sv
// Combinational picker: highest set bit (fixed) or first set bit after ptr_i (round-robin).
module prio_pick
    import enc_pkg::*;
(
    input  logic [N-1:0] pend_i,
    input  logic [W-1:0] ptr_i,
    input  logic         mode_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);
    always_comb begin
        found_o = |pend_i;
        idx_o   = '0;
        if (mode_i == PRIO_RR) begin
            // Scan distances N..1 so the nearest index after ptr_i is assigned last.
            for (int k = N; k >= 1; k--) begin
                if (pend_i[(int'(ptr_i) + k) % N]) idx_o = W'((int'(ptr_i) + k) % N);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pend_i[i]) idx_o = W'(i);
            end
        end
    end
endmodule

// File: rtl/event_encoder8_3.sv
// Sticky event collector that issues one 3-bit event code per valid/ready transfer.
module event_encoder8_3
    import enc_pkg::*;
#(
    parameter logic RR_MODE = PRIO_FIXED
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    output logic [W-1:0] code_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] pending_o,
    output logic         overflow_o,
    input  logic         clr_ovf_i
);
    logic [N-1:0] pend_q, pend_d, clear_vec;
    logic [W-1:0] code_q, code_d, ptr_q, ptr_d, pick_idx;
    logic         valid_q, valid_d, ovf_q, ovf_d;
    logic         found, out_free, issue;

    prio_pick u_pick (
        .pend_i  (pend_q),
        .ptr_i   (ptr_q),
        .mode_i  (RR_MODE),
        .found_o (found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        out_free  = !valid_q || ready_i;
        issue     = out_free && found;
        clear_vec = issue ? (N'(1) << pick_idx) : '0;
        pend_d    = (pend_q & ~clear_vec) | req_i;
        // A repeat request on a still-pending bit is merged, hence lost.
        ovf_d     = (ovf_q && !clr_ovf_i) || |(req_i & pend_q & ~clear_vec);
        valid_d   = valid_q;
        code_d    = code_q;
        ptr_d     = ptr_q;
        if (out_free) begin
            valid_d = issue;
            if (issue) begin
                code_d = pick_idx;
                ptr_d  = pick_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ptr_q   <= W'(N - 1);
        end else begin
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
        end
    end

    assign pending_o  = pend_q;
    assign code_o     = code_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_event_encoder8_3.sv
// Checks fixed-priority and round-robin encoders against a behavioural model, plus directed cases.
module tb_event_encoder8_3;
    import enc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;

    logic [2:0] code [2];
    logic       vld  [2];
    logic [7:0] pend [2];
    logic       ovf  [2];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    event_encoder8_3 #(.RR_MODE(PRIO_FIXED)) u_fx (
        .clk(clk), .rst_n(rst_n), .req_i(req), .code_o(code[0]), .valid_o(vld[0]),
        .ready_i(rdy), .pending_o(pend[0]), .overflow_o(ovf[0]), .clr_ovf_i(clr)
    );
    event_encoder8_3 #(.RR_MODE(PRIO_RR)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_i(req), .code_o(code[1]), .valid_o(vld[1]),
        .ready_i(rdy), .pending_o(pend[1]), .overflow_o(ovf[1]), .clr_ovf_i(clr)
    );

    // Behavioural model: set of pending events, one output slot, last-issued index.
    bit  m_pend [2][8];
    int  m_code [2];
    bit  m_vld  [2];
    bit  m_ovf  [2];
    int  m_last [2];

    function automatic int choose(input bit p [8], input int last, input int mode);
        if (mode == 0) begin
            for (int i = 7; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int d = 1; d <= 8; d++) if (p[(last + d) % 8]) return (last + d) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 8; i++) m_pend[m][i] <= 1'b0;
                m_code[m] <= 0; m_vld[m] <= 1'b0; m_ovf[m] <= 1'b0; m_last[m] <= 7;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int  p;
                bit  lost;
                p = (!m_vld[m] || rdy) ? choose(m_pend[m], m_last[m], m) : -1;
                lost = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (req[i] && m_pend[m][i] && i != p) lost = 1'b1;
                    m_pend[m][i] <= (m_pend[m][i] && i != p) || req[i];
                end
                if (!m_vld[m] || rdy) begin
                    m_vld[m] <= (p >= 0);
                    if (p >= 0) begin
                        m_code[m] <= int'(onehot_to_bin(8'(1 << p)));
                        m_last[m] <= p;
                    end
                end
                m_ovf[m] <= lost || (m_ovf[m] && !clr);
            end
        end
    end

    function automatic logic [7:0] pack(input bit p [8]);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = p[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Compare process: every negedge, both instances against the model.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            chk(m ? "rr.valid" : "fx.valid", 8'(vld[m]), 8'(m_vld[m]));
            chk(m ? "rr.code" : "fx.code", 8'(code[m]), 8'(m_code[m]));
            chk(m ? "rr.pending" : "fx.pending", pend[m], pack(m_pend[m]));
            chk(m ? "rr.overflow" : "fx.overflow", 8'(ovf[m]), 8'(m_ovf[m]));
        end
    end

    task automatic cyc(input logic [7:0] r, input logic rd, input logic c);
        req = r; rdy = rd; clr = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; rdy = 1'b0; clr = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("reset.valid", 8'(vld[0]), 8'h00);
        chk("reset.pending", pend[1], 8'h00);

        // Single events, fixed priority
        cyc(8'h01, 1, 0); chk("t1.nolat", 8'(vld[0]), 8'h00);
        cyc(8'h00, 1, 0); chk("t1.v0", 8'(vld[0]), 8'h01); chk("t1.c0", 8'(code[0]), 8'h00);
        cyc(8'h00, 1, 0); chk("t1.drain", 8'(vld[0]), 8'h00);
        cyc(8'h20, 1, 0); cyc(8'h00, 1, 0); chk("t1.c5", 8'(code[0]), 8'h05);
        cyc(8'h00, 1, 0);
        cyc(8'h80, 1, 0); cyc(8'h00, 1, 0); chk("t1.c7", 8'(code[0]), 8'h07);
        chk("t1.pend", pend[0], 8'h00);
        cyc(8'h00, 1, 0);

        // Multi-hot, fixed priority
        cyc(8'hA6, 1, 0);
        cyc(8'h00, 1, 0); chk("t2.c7", 8'(code[0]), 8'h07);
        cyc(8'h00, 1, 0); chk("t2.c5", 8'(code[0]), 8'h05);
        cyc(8'h00, 1, 0); chk("t2.c2", 8'(code[0]), 8'h02);
        cyc(8'h00, 1, 0); chk("t2.c1", 8'(code[0]), 8'h01); chk("t2.v", 8'(vld[0]), 8'h01);
        cyc(8'h00, 1, 0); chk("t2.drain", 8'(vld[0]), 8'h00);

        // Round-robin from a fresh pointer
        do_reset();
        cyc(8'hFF, 1, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(8'h00, 1, 0); chk("t3.rr_seq", 8'(code[1]), 8'(i));
        end
        cyc(8'h05, 1, 0); chk("t3.drain", 8'(vld[1]), 8'h00);
        cyc(8'h00, 1, 0); chk("t3.c0", 8'(code[1]), 8'h00);
        cyc(8'h00, 1, 0); chk("t3.c2", 8'(code[1]), 8'h02);
        cyc(8'h00, 1, 0);

        // Back-pressure
        cyc(8'h08, 0, 0);
        cyc(8'h10, 0, 0);
        cyc(8'h00, 0, 0);
        chk("t4.v", 8'(vld[0]), 8'h01); chk("t4.c3", 8'(code[0]), 8'h03); chk("t4.pend", pend[0], 8'h10);
        cyc(8'h00, 1, 0); chk("t4.c4", 8'(code[0]), 8'h04);
        cyc(8'h00, 1, 0); chk("t4.drain", 8'(vld[0]), 8'h00);

        // Overflow, clear, same-cycle re-arm
        cyc(8'h01, 0, 0); cyc(8'h00, 0, 0);
        cyc(8'h04, 0, 0); cyc(8'h04, 0, 0);
        chk("t5.ovf", 8'(ovf[0]), 8'h01); chk("t5.pend", pend[0], 8'h04);
        cyc(8'h00, 0, 1); chk("t5.clr", 8'(ovf[0]), 8'h00);
        cyc(8'h04, 1, 0); chk("t5.c2a", 8'(code[0]), 8'h02); chk("t5.rearm", pend[0], 8'h04);
        cyc(8'h00, 1, 0); chk("t5.c2b", 8'(code[0]), 8'h02); chk("t5.noovf", 8'(ovf[0]), 8'h00);
        cyc(8'h00, 1, 0);

        // Asynchronous reset mid-operation
        cyc(8'h01, 0, 0); cyc(8'hC0, 0, 0);
        chk("t6.pre_pend", pend[0], 8'hC0); chk("t6.pre_v", 8'(vld[0]), 8'h01);
        #2 rst_n = 1'b0; req = 8'hFF;
        #1;
        chk("t6.rst_v", 8'(vld[0]), 8'h00); chk("t6.rst_p", pend[0], 8'h00);
        chk("t6.rst_c", 8'(code[0]), 8'h00); chk("t6.rst_rr", pend[1], 8'h00);
        @(negedge clk); req = '0; rst_n = 1'b1;
        cyc(8'h00, 1, 0); cyc(8'h00, 1, 0);
        chk("t6.idle", 8'(vld[0]), 8'h00); chk("t6.idle_p", pend[0], 8'h00);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : '0;
            if ($urandom_range(0, 400) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk); rst_n = 1'b1;
            end else begin
                cyc(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/event_encoder8_3.md
Name: event_encoder8_3

Overview:
- Inverse companion of the team's 3-to-8 decoder. Collects one-hot/multi-hot event pulses on 8 request lines and latches them as sticky pending bits.
- Encodes each pending event into a 3-bit index and presents one index per transfer on a valid/ready output.
- Sits between raw event sources (decoded strobes, interrupt-style lines) and a consumer that needs a compact binary code.

Parameters:
- N, 8, number of request lines (fixed 8 for this block; parameterised for the package).
- W, 3, code width, equal to clog2(N).
- RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin starting after the last issued index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, active-low.
- req_i  input  8  event pulses; any number of bits may be high per cycle.
- code_o  output  3  encoded index of the issued event.
- valid_o  output  1  code_o holds an issued event.
- ready_i  input  1  consumer accepts code_o when valid_o && ready_i.
- pending_o  output  8  current sticky pending register.
- overflow_o  output  1  sticky; an event was lost.
- clr_ovf_i  input  1  synchronous clear of overflow_o.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: pending_o=0, code_o=0, valid_o=0, overflow_o=0, RR pointer=7, so the first RR search starts at index 0.
- out_free = !valid_o || ready_i.
- Issue: when out_free && pending_o != 0, on that edge:
  - code_o <= picked index;
  - valid_o <= 1;
  - pending[pick] is cleared;
  - RR pointer <= pick.
- Drain: when out_free && pending_o == 0, valid_o <= 0 and code_o holds its last value.
- Pick rules:
  - Fixed mode: the highest set index of pending_o.
  - RR mode: the first set index scanning upward from pointer+1, wrapping 7 to 0.
- Pending update, every edge: pending <= (pending & ~clear_vec) | req_i, where clear_vec is one-hot of the pick when issuing, else 0. An event issued is no longer pending; in-flight events live only in code_o.
- Latency: req_i[i] high before edge k sets pending[i] at k. With the output free and no competitor, valid_o=1 and code_o=i after edge k+1.
- Back-pressure: while valid_o && !ready_i, code_o and valid_o hold and no new pick occurs; pending keeps accumulating.
- Simultaneous same-bit request and issue: req_i[i] in the same cycle that bit i is picked re-sets pending[i]. This is a new event, not an overflow.
- Overflow: overflow_o <= 1 if any req_i[i] && pending[i] && !clear_vec[i]. The repeat event is merged, so it is lost.
- clr_ovf_i: clears overflow_o. A new overflow in the same cycle wins, so overflow_o stays 1.
- Throughput: one code per cycle when ready_i is held high.
- Reset mid-operation: all pending events and any in-flight code are discarded immediately and asynchronously. Requests during reset are ignored.
- No combinational path from req_i or ready_i to any output; all outputs are registered.

Decomposition:
- Shared package enc_pkg holds:
  - N=8 and W=3;
  - mode constants PRIO_FIXED=0 and PRIO_RR=1;
  - function onehot_to_bin for checking.
- One natural sub-module: prio_pick. It is combinational; inputs are the pending vector, the pointer and the mode; outputs are found and index. It is reusable by other arbiters in the design.

Test Plan:
1. Single events, fixed mode, ready_i=1: pulse req_i=00000001, then 00100000, then 10000000 with gaps -> code_o=0, 5, 7 in turn, each valid for one cycle, two edges after the request; pending_o returns to 0.
2. Multi-hot, fixed mode: one cycle req_i=10100110, ready_i=1 -> codes 7, 5, 2, 1 on consecutive cycles, then valid_o=0.
3. Round-robin: RR_MODE=1, one cycle req_i=11111111, ready_i=1 -> codes 0,1,...,7 consecutively. Then pulse req_i=00000101 -> codes 0, 2.
4. Back-pressure: ready_i=0, pulse req_i=00001000 then 00010000 -> valid_o=1, code_o=3 held, pending_o=00010000. Raise ready_i -> code 4 next, then valid_o=0.
5. Overflow and same-cycle re-arm: ready_i=0, pulse req_i[2] twice -> overflow_o=1, pending_o=00000100. Pulse clr_ovf_i -> overflow_o=0. With ready_i=1, pulse req_i[2] on the exact cycle bit 2 is issued -> code 2 issued twice, overflow_o stays 0.
6. Reset mid-operation: with pending_o=11000000 and valid_o=1, drop rst_n between edges -> all outputs 0 immediately. After release, no code is issued until a new request arrives.
